// File: rtl/stream_perf_monitor.sv
// Per-channel valid/ready stream statistics: handshake, frame-active, stall and
// frame counters with a two-state frame tracker, done pulse and sticky overflow.
module stream_perf_monitor #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SATURATE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [N_CH-1:0]         valid,
    input  logic [N_CH-1:0]         ready,
    input  logic [N_CH-1:0]         last,
    output logic [N_CH*CNT_W-1:0]   beat_cnt,
    output logic [N_CH*CNT_W-1:0]   active_cnt,
    output logic [N_CH*CNT_W-1:0]   stall_cnt,
    output logic [N_CH*CNT_W-1:0]   frame_cnt,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         frame_done,
    output logic [N_CH-1:0]         ovf
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    // Returns {overflow, next value}; all-ones either holds or wraps to zero.
    function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return {1'b1, (SATURATE != 0) ? c : {CNT_W{1'b0}}};
        end
        return {1'b0, c + CNT_W'(1)};
    endfunction

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        logic             hs, stl, act, fin;
        logic [0:0]       state_q, state_d;
        logic [CNT_W-1:0] beat_q, beat_d, act_q, act_d;
        logic [CNT_W-1:0] stall_q, stall_d, frame_q, frame_d;
        logic             done_q, done_d, ovf_q, ovf_d;
        logic [CNT_W:0]   beat_inc, act_inc, stall_inc, frame_inc;

        // Every event term carries enable, so enable low freezes everything.
        assign hs  = enable & valid[i] & ready[i];
        assign stl = enable & valid[i] & ~ready[i];
        assign act = enable & ((state_q == ACTIVE) | hs);
        assign fin = hs & last[i];

        assign beat_inc  = bump(beat_q);
        assign act_inc   = bump(act_q);
        assign stall_inc = bump(stall_q);
        assign frame_inc = bump(frame_q);

        always_comb begin
            state_d = state_q;
            beat_d  = beat_q;
            act_d   = act_q;
            stall_d = stall_q;
            frame_d = frame_q;
            done_d  = 1'b0;
            ovf_d   = ovf_q;
            if (clear) begin
                state_d = IDLE;
                beat_d  = '0;
                act_d   = '0;
                stall_d = '0;
                frame_d = '0;
                ovf_d   = 1'b0;
            end else begin
                if (state_q == IDLE) begin
                    if (hs & ~last[i]) state_d = ACTIVE;
                end else begin
                    if (fin) state_d = IDLE;
                end
                if (hs) begin
                    beat_d = beat_inc[CNT_W-1:0];
                    if (beat_inc[CNT_W]) ovf_d = 1'b1;
                end
                if (act) begin
                    act_d = act_inc[CNT_W-1:0];
                    if (act_inc[CNT_W]) ovf_d = 1'b1;
                end
                if (stl) begin
                    stall_d = stall_inc[CNT_W-1:0];
                    if (stall_inc[CNT_W]) ovf_d = 1'b1;
                end
                if (fin) begin
                    frame_d = frame_inc[CNT_W-1:0];
                    if (frame_inc[CNT_W]) ovf_d = 1'b1;
                end
                done_d = fin;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                beat_q  <= '0;
                act_q   <= '0;
                stall_q <= '0;
                frame_q <= '0;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                beat_q  <= beat_d;
                act_q   <= act_d;
                stall_q <= stall_d;
                frame_q <= frame_d;
                done_q  <= done_d;
                ovf_q   <= ovf_d;
            end
        end

        assign beat_cnt[i*CNT_W +: CNT_W]   = beat_q;
        assign active_cnt[i*CNT_W +: CNT_W] = act_q;
        assign stall_cnt[i*CNT_W +: CNT_W]  = stall_q;
        assign frame_cnt[i*CNT_W +: CNT_W]  = frame_q;
        assign busy[i]       = (state_q == ACTIVE);
        assign frame_done[i] = done_q;
        assign ovf[i]        = ovf_q;
    end

endmodule

// File: tb/tb_stream_perf_monitor.sv
// Bench for stream_perf_monitor: saturating and wrapping instances side by side,
// directed scenarios plus random traffic against an unbounded-count model.
module tb_stream_perf_monitor;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic [1:0]  valid, ready, last;

    logic [15:0] beat_s, act_s, stall_s, frame_s;
    logic [15:0] beat_w, act_w, stall_w, frame_w;
    logic [1:0]  busy_s, done_s, ovf_s;
    logic [1:0]  busy_w, done_w, ovf_w;

    int checks = 0;
    int errors = 0;

    // Model: true event totals since last clear/reset, mapped to 8 bits on compare.
    longint beat_n[2], act_n[2], stl_n[2], frm_n[2];
    bit     busy_m[2], done_m[2];

    stream_perf_monitor #(.N_CH(2), .CNT_W(8), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .valid(valid), .ready(ready), .last(last),
        .beat_cnt(beat_s), .active_cnt(act_s), .stall_cnt(stall_s), .frame_cnt(frame_s),
        .busy(busy_s), .frame_done(done_s), .ovf(ovf_s));

    stream_perf_monitor #(.N_CH(2), .CNT_W(8), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .valid(valid), .ready(ready), .last(last),
        .beat_cnt(beat_w), .active_cnt(act_w), .stall_cnt(stall_w), .frame_cnt(frame_w),
        .busy(busy_w), .frame_done(done_w), .ovf(ovf_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ecnt(input longint n, input bit sat);
        if (sat && n > 255) return 8'hFF;
        return 8'(n % 256);
    endfunction

    function automatic logic [7:0] sl(input logic [15:0] v, input int ch);
        return v[ch*8 +: 8];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            beat_n[c] = 0; act_n[c] = 0; stl_n[c] = 0; frm_n[c] = 0;
            busy_m[c] = 0; done_m[c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            bit hs, st;
            hs = enable && valid[c] && ready[c];
            st = enable && valid[c] && !ready[c];
            if (clear) begin
                beat_n[c] = 0; act_n[c] = 0; stl_n[c] = 0; frm_n[c] = 0;
                busy_m[c] = 0; done_m[c] = 0;
            end else begin
                if (hs) beat_n[c]++;
                if (enable && (busy_m[c] || hs)) act_n[c]++;
                if (st) stl_n[c]++;
                if (hs && last[c]) frm_n[c]++;
                done_m[c] = hs && last[c];
                if (hs) busy_m[c] = !last[c];
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 2; c++) begin
            bit ov;
            ov = (beat_n[c] > 255) || (act_n[c] > 255) || (stl_n[c] > 255) || (frm_n[c] > 255);
            chk($sformatf("sat beat ch%0d", c),   sl(beat_s, c),  ecnt(beat_n[c], 1));
            chk($sformatf("sat active ch%0d", c), sl(act_s, c),   ecnt(act_n[c], 1));
            chk($sformatf("sat stall ch%0d", c),  sl(stall_s, c), ecnt(stl_n[c], 1));
            chk($sformatf("sat frame ch%0d", c),  sl(frame_s, c), ecnt(frm_n[c], 1));
            chk($sformatf("sat busy ch%0d", c),   busy_s[c], busy_m[c]);
            chk($sformatf("sat done ch%0d", c),   done_s[c], done_m[c]);
            chk($sformatf("sat ovf ch%0d", c),    ovf_s[c], ov);
            chk($sformatf("wrap beat ch%0d", c),   sl(beat_w, c),  ecnt(beat_n[c], 0));
            chk($sformatf("wrap active ch%0d", c), sl(act_w, c),   ecnt(act_n[c], 0));
            chk($sformatf("wrap stall ch%0d", c),  sl(stall_w, c), ecnt(stl_n[c], 0));
            chk($sformatf("wrap frame ch%0d", c),  sl(frame_w, c), ecnt(frm_n[c], 0));
            chk($sformatf("wrap busy ch%0d", c),   busy_w[c], busy_m[c]);
            chk($sformatf("wrap done ch%0d", c),   done_w[c], done_m[c]);
            chk($sformatf("wrap ovf ch%0d", c),    ovf_w[c], ov);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic en, input logic clr, input logic [1:0] v,
                         input logic [1:0] r, input logic [1:0] l);
        enable = en; clear = clr; valid = v; ready = r; last = l;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " beat"},  {beat_s, beat_w}, 32'h0);
        chk({tag, " active"}, {act_s, act_w}, 32'h0);
        chk({tag, " stall"}, {stall_s, stall_w}, 32'h0);
        chk({tag, " frame"}, {frame_s, frame_w}, 32'h0);
        chk({tag, " flags"}, {busy_s, done_s, ovf_s, busy_w, done_w, ovf_w}, 12'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 2'b00, 2'b00, 2'b00);
        model_reset();
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // 4-beat frame on ch0, ready held high
        drive(1, 0, 2'b01, 2'b01, 2'b00);
        step(); step(); step();
        last = 2'b01;
        step();
        chk("f4 beat0", sl(beat_s, 0), 8'd4);
        chk("f4 active0", sl(act_s, 0), 8'd4);
        chk("f4 stall0", sl(stall_s, 0), 8'd0);
        chk("f4 frame0", sl(frame_s, 0), 8'd1);
        chk("f4 done", done_s, 2'b01);
        chk("f4 ch1 zero", {sl(beat_s, 1), sl(act_s, 1), sl(stall_s, 1), sl(frame_s, 1)}, 32'h0);
        drive(1, 0, 2'b00, 2'b00, 2'b00);
        step();
        chk("f4 done drop", done_s, 2'b00);
        clear = 1'b1; step(); clear = 1'b0;

        // 3-beat frame with two stall cycles
        drive(1, 0, 2'b01, 2'b01, 2'b00);
        step();
        chk("stall busy after b1", busy_s[0], 1'b1);
        ready = 2'b00;
        step(); step();
        ready = 2'b01;
        step();
        chk("stall busy mid", busy_s[0], 1'b1);
        last = 2'b01;
        step();
        chk("stall busy after b3", busy_s[0], 1'b0);
        chk("stall beat0", sl(beat_s, 0), 8'd3);
        chk("stall active0", sl(act_s, 0), 8'd5);
        chk("stall stall0", sl(stall_s, 0), 8'd2);
        chk("stall frame0", sl(frame_s, 0), 8'd1);
        drive(1, 1, 2'b00, 2'b00, 2'b00); step(); clear = 1'b0;

        // single-beat frame from IDLE
        drive(1, 0, 2'b01, 2'b01, 2'b01);
        step();
        chk("single beat0", sl(beat_s, 0), 8'd1);
        chk("single active0", sl(act_s, 0), 8'd1);
        chk("single frame0", sl(frame_s, 0), 8'd1);
        chk("single busy", busy_s[0], 1'b0);
        chk("single done", done_s[0], 1'b1);
        drive(1, 0, 2'b00, 2'b00, 2'b00);
        step();
        chk("single done drop", done_s[0], 1'b0);
        clear = 1'b1; step(); clear = 1'b0;

        // 300 back-to-back single-beat frames
        drive(1, 0, 2'b01, 2'b01, 2'b01);
        for (int k = 0; k < 300; k++) step();
        chk("sat300 beat0", sl(beat_s, 0), 8'd255);
        chk("sat300 frame0", sl(frame_s, 0), 8'd255);
        chk("sat300 ovf0", ovf_s[0], 1'b1);
        chk("wrap300 beat0", sl(beat_w, 0), 8'd44);
        chk("wrap300 frame0", sl(frame_w, 0), 8'd44);
        chk("wrap300 ovf0", ovf_w[0], 1'b1);
        drive(1, 0, 2'b00, 2'b00, 2'b00);
        step();
        chk("ovf sticky", {ovf_s[0], ovf_w[0]}, 2'b11);
        clear = 1'b1; step(); clear = 1'b0;

        // enable low mid-frame freezes, then clear with a handshake
        drive(1, 0, 2'b01, 2'b01, 2'b00);
        step();
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("frozen beat0", sl(beat_s, 0), 8'd1);
            chk("frozen busy0", busy_s[0], 1'b1);
        end
        drive(1, 1, 2'b01, 2'b01, 2'b00);
        step();
        chk_all_zero("clear hs");
        clear = 1'b0;

        // async reset mid-frame, then a 2-beat frame
        drive(1, 0, 2'b11, 2'b11, 2'b00);
        step(); step();
        rst_n = 1'b0;
        #2;
        chk_all_zero("async rst");
        model_reset();
        rst_n = 1'b1;
        drive(1, 0, 2'b01, 2'b01, 2'b00);
        step();
        last = 2'b01;
        step();
        chk("post rst beat0", sl(beat_s, 0), 8'd2);
        chk("post rst frame0", sl(frame_s, 0), 8'd1);

        // clear while disabled
        drive(0, 1, 2'b00, 2'b00, 2'b00);
        step();
        chk_all_zero("clear disabled");

        // random traffic
        for (int k = 0; k < 2000; k++) begin
            logic [1:0] l;
            for (int c = 0; c < 2; c++) l[c] = ($urandom_range(0, 9) < 3);
            drive(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 63) == 0),
                  2'($urandom), 2'($urandom), l);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_perf_monitor.md
STREAM_PERF_MONITOR -- requirements
Module: stream_perf_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of monitored valid/ready streams (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, width of every statistics counter (8..48).
REQ-003 SHALL have parameter SATURATE, default 1: 1 = counters saturate at all-ones; 0 = counters wrap to zero.
REQ-004 SHALL use one clock and an asynchronous active-low reset, listed as the first two ports below.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  high = monitoring active; low = all state frozen.
REQ-008 clear  input  1  synchronous clear of all statistics.
REQ-009 valid  input  N_CH  per-channel stream valid.
REQ-010 ready  input  N_CH  per-channel stream ready.
REQ-011 last  input  N_CH  per-channel end-of-frame marker, qualified by valid.
REQ-012 beat_cnt  output  N_CH*CNT_W  handshake count; channel i occupies bits [i*CNT_W +: CNT_W] (same packing for all vector counters).
REQ-013 active_cnt  output  N_CH*CNT_W  frame-active cycle count.
REQ-014 stall_cnt  output  N_CH*CNT_W  backpressure cycle count.
REQ-015 frame_cnt  output  N_CH*CNT_W  completed-frame count.
REQ-016 busy  output  N_CH  channel FSM in ACTIVE.
REQ-017 frame_done  output  N_CH  one-cycle pulse per completed frame.
REQ-018 ovf  output  N_CH  sticky: any counter of that channel overflowed.

Function
REQ-019 Per channel: hs = enable & valid & ready; stl = enable & valid & ~ready; channels SHALL be fully independent.
REQ-020 Per-channel FSM SHALL have states IDLE and ACTIVE; busy = (state == ACTIVE).
REQ-021 IDLE -> ACTIVE on hs & ~last; IDLE stays IDLE on hs & last (single-beat frame) and on no hs.
REQ-022 ACTIVE -> IDLE on hs & last; otherwise ACTIVE is held.
REQ-023 beat_cnt SHALL increment by 1 on every hs.
REQ-024 active_cnt SHALL increment on every cycle with enable & (busy | hs), so an N-beat frame with S stall cycles adds N+S.
REQ-025 stall_cnt SHALL increment on every stl cycle in either state.
REQ-026 frame_cnt SHALL increment on every hs & last.
REQ-027 frame_done SHALL be registered and high for exactly the one cycle after the hs & last cycle.
REQ-028 Counter and state updates SHALL be visible on outputs the cycle after the event (1-cycle latency); all outputs are driven directly from registers.
REQ-029 enable low SHALL freeze FSM, counters and ovf; frame_done SHALL be 0 in the cycle after an enable-low cycle.
REQ-030 When a counter is all-ones and increments: SATURATE=1 holds all-ones; SATURATE=0 wraps to 0; in both cases the channel's ovf SHALL set.
REQ-031 ovf SHALL stay set until clear or reset.
REQ-032 clear SHALL take priority over every increment and transition: next cycle all counters, ovf, frame_done = 0 and all FSMs in IDLE; a beat coinciding with clear is not counted.
REQ-033 clear SHALL act regardless of enable.

Reset
REQ-034 rst_n low SHALL immediately, without a clock edge, force all counters to 0, busy = 0, frame_done = 0, ovf = 0 and all FSMs to IDLE, including mid-frame.
REQ-035 After rst_n deasserts, the first rising edge SHALL process events normally.

Verification (N_CH=2, CNT_W=8 unless stated)
REQ-036 Ch0 4-beat frame, ready held high, enable high -> beat 4, active 4, stall 0, frame 1; frame_done[0] one pulse the cycle after beat 4; ch1 all 0.
REQ-037 Ch0 3-beat frame, ready low for 2 cycles mid-frame with valid high -> beat 3, active 5, stall 2, frame 1; busy high from the cycle after beat 1 until the cycle after beat 3.
REQ-038 Single beat valid & ready & last in IDLE -> beat 1, active 1, frame 1, busy never high, frame_done pulses once.
REQ-039 300 back-to-back single-beat frames: SATURATE=1 -> beat 255, frame 255, ovf 1; SATURATE=0 -> beat 44, frame 44, ovf 1.
REQ-040 enable low for 3 cycles mid-frame with valid & ready high -> counters and busy unchanged over those cycles; then clear coinciding with a handshake -> next cycle all outputs 0.
REQ-041 rst_n pulsed low between clock edges mid-frame -> all outputs 0 before the next rising edge; a subsequent 2-beat frame -> beat 2, frame 1.
